// File: rtl/uart_param_if.sv
// Byte-stream client side of the UART core: TX valid/ready handshake plus
// received word and error flags. The client uses master, the core slave.
interface uart_param_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              parity_error;
  logic              stop_error;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, parity_error, stop_error
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, parity_error, stop_error
  );
endinterface

// File: rtl/uart_param.sv
// Parametrised full-duplex UART: configurable data width, oversampling,
// runtime baud divisor, none/even/odd parity, 1 or 2 stop bits (TX) and
// internal loopback. TX and RX are independent FSMs in one clock domain;
// every frame latches its own copy of the line settings.
module uart_param #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       parity_mode,
  input  logic             stop_bits,
  input  logic             loopback,
  output logic             txd,
  input  logic             rxd,
  uart_param_if.slave      bus
);

  // Wide enough for 2P-1 with P = OVERSAMPLE * 2^DIV_W in the worst case.
  localparam int CNT_W = DIV_W + $clog2(OVERSAMPLE) + 1;
  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Bit period derived from the live inputs; only used at the moment a
  // frame starts, after which the latched copy governs the frame.
  logic [CNT_W-1:0] w_div_ext;
  logic [CNT_W-1:0] w_period_in;
  logic             w_par_en_in;
  logic             w_par_odd_in;

  assign w_div_ext    = {{(CNT_W-DIV_W){1'b0}}, baud_div};
  assign w_period_in  = (w_div_ext + CNT_W'(1)) * CNT_W'(OVERSAMPLE);
  assign w_par_en_in  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
  assign w_par_odd_in = (parity_mode == 2'b10);

  // ---------------------------------------------------------------- TX
  state_t            r_tx_state;
  logic [CNT_W-1:0]  r_tx_cnt;
  logic [CNT_W-1:0]  r_tx_period;
  logic [DATA_W-1:0] r_tx_shift;
  logic [IDX_W-1:0]  r_tx_idx;
  logic              r_tx_par_en;
  logic              r_tx_par;
  logic              r_tx_stop2;
  logic              r_txd;
  logic              r_tx_ready;

  logic w_tx_bit_end;
  logic w_tx_stop_end;

  assign w_tx_bit_end  = (r_tx_cnt == r_tx_period - CNT_W'(1));
  assign w_tx_stop_end = r_tx_stop2 ? (r_tx_cnt == (r_tx_period << 1) - CNT_W'(1))
                                    : w_tx_bit_end;

  // TX frame sequencer; txd and tx_ready are registered so the line never glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state  <= S_IDLE;
      r_tx_cnt    <= '0;
      r_tx_period <= '0;
      r_tx_shift  <= '0;
      r_tx_idx    <= '0;
      r_tx_par_en <= 1'b0;
      r_tx_par    <= 1'b0;
      r_tx_stop2  <= 1'b0;
      r_txd       <= 1'b1;
      r_tx_ready  <= 1'b1;
    end else begin
      case (r_tx_state)
        S_IDLE: begin
          // tx_ready is high in this state, so tx_valid alone means transfer.
          if (bus.tx_valid) begin
            r_tx_shift  <= bus.tx_data;
            r_tx_par    <= (^bus.tx_data) ^ w_par_odd_in;
            r_tx_par_en <= w_par_en_in;
            r_tx_stop2  <= stop_bits;
            r_tx_period <= w_period_in;
            r_tx_cnt    <= '0;
            r_txd       <= 1'b0;
            r_tx_ready  <= 1'b0;
            r_tx_state  <= S_START;
          end
        end
        S_START: begin
          if (w_tx_bit_end) begin
            r_tx_cnt   <= '0;
            r_txd      <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_idx   <= '0;
            r_tx_state <= S_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_tx_bit_end) begin
            r_tx_cnt <= '0;
            if (r_tx_idx == IDX_W'(DATA_W-1)) begin
              if (r_tx_par_en) begin
                r_txd      <= r_tx_par;
                r_tx_state <= S_PARITY;
              end else begin
                r_txd      <= 1'b1;
                r_tx_state <= S_STOP;
              end
            end else begin
              r_txd      <= r_tx_shift[0];
              r_tx_shift <= r_tx_shift >> 1;
              r_tx_idx   <= r_tx_idx + IDX_W'(1);
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (w_tx_bit_end) begin
            r_tx_cnt   <= '0;
            r_txd      <= 1'b1;
            r_tx_state <= S_STOP;
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          // One counter run covers both stop bits when two are configured.
          if (w_tx_stop_end) begin
            r_tx_cnt   <= '0;
            r_tx_ready <= 1'b1;
            r_tx_state <= S_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_tx_state <= S_IDLE;
          r_txd      <= 1'b1;
          r_tx_ready <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- RX
  logic w_rx_src;
  logic r_sync1;
  logic r_sync2;
  logic r_rx_prev;
  logic w_rx_fall;

  assign w_rx_src  = loopback ? r_txd : rxd;
  assign w_rx_fall = r_rx_prev & ~r_sync2;

  // Two-flop synchroniser plus one history flop for start-edge detection.
  // Requiring a 1->0 edge means a line stuck low after a bad stop bit
  // cannot masquerade as a new start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= w_rx_src;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  state_t            r_rx_state;
  logic [CNT_W-1:0]  r_rx_cnt;
  logic [CNT_W-1:0]  r_rx_period;
  logic              r_rx_par_en;
  logic              r_rx_par_odd;
  logic [DATA_W-1:0] r_rx_shift;
  logic [IDX_W-1:0]  r_rx_idx;
  logic              r_rx_perr_pend;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_parity_error;
  logic              r_stop_error;

  logic w_rx_half_end;
  logic w_rx_bit_end;

  assign w_rx_half_end = (r_rx_cnt == (r_rx_period >> 1) - CNT_W'(1));
  assign w_rx_bit_end  = (r_rx_cnt == r_rx_period - CNT_W'(1));

  // RX frame sequencer: mid-bit sampling, results published one cycle after the stop sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state     <= S_IDLE;
      r_rx_cnt       <= '0;
      r_rx_period    <= '0;
      r_rx_par_en    <= 1'b0;
      r_rx_par_odd   <= 1'b0;
      r_rx_shift     <= '0;
      r_rx_idx       <= '0;
      r_rx_perr_pend <= 1'b0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_parity_error <= 1'b0;
      r_stop_error   <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_rx_state)
        S_IDLE: begin
          if (w_rx_fall) begin
            r_rx_period    <= w_period_in;
            r_rx_par_en    <= w_par_en_in;
            r_rx_par_odd   <= w_par_odd_in;
            r_rx_perr_pend <= 1'b0;
            r_rx_cnt       <= '0;
            r_rx_state     <= S_START;
          end
        end
        S_START: begin
          if (w_rx_half_end) begin
            r_rx_cnt <= '0;
            r_rx_idx <= '0;
            // A high sample here was a glitch, not a start bit.
            r_rx_state <= r_sync2 ? S_IDLE : S_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_rx_bit_end) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_sync2, r_rx_shift[DATA_W-1:1]};
            if (r_rx_idx == IDX_W'(DATA_W-1)) begin
              r_rx_state <= r_rx_par_en ? S_PARITY : S_STOP;
            end else begin
              r_rx_idx <= r_rx_idx + IDX_W'(1);
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (w_rx_bit_end) begin
            r_rx_cnt       <= '0;
            r_rx_perr_pend <= (^r_rx_shift) ^ r_sync2 ^ r_rx_par_odd;
            r_rx_state     <= S_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (w_rx_bit_end) begin
            r_rx_cnt       <= '0;
            r_rx_data      <= r_rx_shift;
            r_parity_error <= r_rx_perr_pend;
            r_stop_error   <= ~r_sync2;
            r_rx_valid     <= 1'b1;
            r_rx_state     <= S_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  assign txd              = r_txd;
  assign bus.tx_ready     = r_tx_ready;
  assign bus.rx_data      = r_rx_data;
  assign bus.rx_valid     = r_rx_valid;
  assign bus.parity_error = r_parity_error;
  assign bus.stop_error   = r_stop_error;

endmodule
